// File: rtl/prt_dp_pm_hpd_pkg.sv
// Shared types and constants for the DisplayPort source-side HPD receiver.
package prt_dp_pm_hpd_pkg;

  typedef enum logic [2:0] {
    sm_rst,
    sm_unplugged,
    sm_plug_dbc,
    sm_plugged,
    sm_low
  } hpd_sm_t;

  localparam logic [1:0] ADR_CTL = 2'd0;
  localparam logic [1:0] ADR_STA = 2'd1;
  localparam logic [1:0] ADR_PW  = 2'd2;
  localparam logic [1:0] ADR_ID  = 2'd3;

  localparam int CTL_RUN    = 0;
  localparam int CTL_IE     = 1;
  localparam int STA_LVL    = 0;
  localparam int STA_UNPLUG = 1;
  localparam int STA_PLUG   = 2;
  localparam int STA_IRQ    = 3;

  localparam logic [31:0] ID_VAL = 32'hdeadcafe;

  // All time constants are in 1 us beats; simulation mode shrinks them.
  function automatic logic [15:0] plug_val(input int sim);
    return (sim != 0) ? 16'd5 : 16'd100;
  endfunction

  function automatic logic [15:0] ipw_min(input int sim);
    return (sim != 0) ? 16'd3 : 16'd250;
  endfunction

  function automatic logic [15:0] hms_val(input int sim);
    return (sim != 0) ? 16'd10 : 16'd2000;
  endfunction

endpackage

// File: rtl/prt_dp_lb_if.sv
// Local bus: master drives adr/din/rd/wr, slave answers with dout/vld.
interface prt_dp_lb_if;
  logic [1:0]  adr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        rd;
  logic        wr;
  logic        vld;

  modport lb_in  (input adr, din, rd, wr, output dout, vld);
  modport lb_out (output adr, din, rd, wr, input dout, vld);
endinterface

// File: rtl/prt_dp_lib_edge.sv
// Registered edge detector: one-cycle pulses on rising and falling edges of A_IN.
module prt_dp_lib_edge (
  input  logic CLK_IN,
  input  logic RST_IN,
  input  logic A_IN,
  output logic RE_OUT,
  output logic FE_OUT
);

  logic a_q;

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      a_q    <= 1'b0;
      RE_OUT <= 1'b0;
      FE_OUT <= 1'b0;
    end else begin
      a_q    <= A_IN;
      RE_OUT <= A_IN & ~a_q;
      FE_OUT <= ~A_IN & a_q;
    end
  end

endmodule

// File: rtl/prt_dp_pm_hpd_tx.sv
// Source-side HPD receiver: debounces plug, classifies low pulses into IRQ/unplug,
// and reports sticky flags, last pulse width and a level interrupt on the local bus.
module prt_dp_pm_hpd_tx
  import prt_dp_pm_hpd_pkg::*;
#(
  parameter int P_SIM = 0
) (
  input  logic          CLK_IN,
  input  logic          RST_IN,
  prt_dp_lb_if.lb_in    LB_IF,
  input  logic          BEAT_IN,
  input  logic          HPD_IN,
  output logic          IRQ_OUT
);

  localparam logic [15:0] PLUG_VAL = plug_val(P_SIM);
  localparam logic [15:0] IPW_MIN  = ipw_min(P_SIM);
  localparam logic [15:0] HMS_VAL  = hms_val(P_SIM);

  logic [1:0]  lb_adr_q;
  logic [3:0]  lb_din_q;
  logic        lb_rd_q;
  logic        lb_wr_q;
  logic        din_unused;
  logic        ctl_run;
  logic        ctl_ie;
  logic        hpd_meta;
  logic        hpd_sync;
  logic        hpd_re;
  logic        hpd_fe;
  logic        beat_re;
  logic        beat_fe_unused;
  logic [3:1]  sta_clr;
  hpd_sm_t     state;
  logic [15:0] cnt;
  logic        lvl;
  logic        flg_unplug;
  logic        flg_plug;
  logic        flg_irq;
  logic [15:0] pw;
  logic [31:0] rd_data;

  assign din_unused = ^LB_IF.din[31:4];

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      lb_adr_q <= '0;
      lb_din_q <= '0;
      lb_rd_q  <= 1'b0;
      lb_wr_q  <= 1'b0;
      ctl_run  <= 1'b0;
      ctl_ie   <= 1'b0;
      hpd_meta <= 1'b0;
      hpd_sync <= 1'b0;
    end else begin
      lb_adr_q <= LB_IF.adr;
      lb_din_q <= LB_IF.din[3:0];
      lb_rd_q  <= LB_IF.rd;
      lb_wr_q  <= LB_IF.wr;
      hpd_meta <= HPD_IN;
      hpd_sync <= hpd_meta;
      if (lb_wr_q && lb_adr_q == ADR_CTL) begin
        ctl_run <= lb_din_q[CTL_RUN];
        ctl_ie  <= lb_din_q[CTL_IE];
      end
    end
  end

  prt_dp_lib_edge u_beat_edge (
    .CLK_IN (CLK_IN),
    .RST_IN (RST_IN),
    .A_IN   (BEAT_IN),
    .RE_OUT (beat_re),
    .FE_OUT (beat_fe_unused)
  );

  prt_dp_lib_edge u_hpd_edge (
    .CLK_IN (CLK_IN),
    .RST_IN (RST_IN),
    .A_IN   (hpd_sync),
    .RE_OUT (hpd_re),
    .FE_OUT (hpd_fe)
  );

  assign sta_clr = (lb_wr_q && lb_adr_q == ADR_STA) ? lb_din_q[3:1] : 3'd0;

  // Flag W1C is applied first so that an event assigned later in the same cycle wins.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state      <= sm_rst;
      cnt        <= '0;
      lvl        <= 1'b0;
      flg_unplug <= 1'b0;
      flg_plug   <= 1'b0;
      flg_irq    <= 1'b0;
      pw         <= '0;
    end else if (!ctl_run) begin
      state      <= sm_rst;
      cnt        <= '0;
      lvl        <= 1'b0;
      flg_unplug <= 1'b0;
      flg_plug   <= 1'b0;
      flg_irq    <= 1'b0;
      pw         <= '0;
    end else begin
      flg_unplug <= flg_unplug & ~sta_clr[STA_UNPLUG];
      flg_plug   <= flg_plug & ~sta_clr[STA_PLUG];
      flg_irq    <= flg_irq & ~sta_clr[STA_IRQ];
      if (beat_re && cnt != 16'hffff) cnt <= cnt + 16'd1;
      case (state)
        sm_rst: begin
          lvl   <= 1'b0;
          cnt   <= '0;
          state <= sm_unplugged;
        end
        sm_unplugged: begin
          if (hpd_sync) begin
            cnt   <= '0;
            state <= sm_plug_dbc;
          end
        end
        sm_plug_dbc: begin
          if (!hpd_sync) begin
            cnt   <= '0;
            state <= sm_unplugged;
          end else if (cnt == PLUG_VAL) begin
            flg_plug <= 1'b1;
            lvl      <= 1'b1;
            cnt      <= '0;
            state    <= sm_plugged;
          end
        end
        sm_plugged: begin
          if (hpd_fe) begin
            cnt   <= '0;
            state <= sm_low;
          end
        end
        sm_low: begin
          if (cnt == HMS_VAL) begin
            flg_unplug <= 1'b1;
            lvl        <= 1'b0;
            pw         <= cnt;
            cnt        <= '0;
            state      <= sm_unplugged;
          end else if (hpd_re) begin
            if (cnt >= IPW_MIN) begin
              flg_irq <= 1'b1;
              pw      <= cnt;
            end
            cnt   <= '0;
            state <= sm_plugged;
          end
        end
        default: begin
          cnt   <= '0;
          state <= sm_rst;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (lb_adr_q)
      ADR_CTL: begin
        rd_data[CTL_RUN] = ctl_run;
        rd_data[CTL_IE]  = ctl_ie;
      end
      ADR_STA: begin
        rd_data[STA_LVL]    = lvl;
        rd_data[STA_UNPLUG] = flg_unplug;
        rd_data[STA_PLUG]   = flg_plug;
        rd_data[STA_IRQ]    = flg_irq;
      end
      ADR_PW:  rd_data[15:0] = pw;
      default: rd_data = ID_VAL;
    endcase
  end

  assign LB_IF.dout = rd_data;
  assign LB_IF.vld  = lb_rd_q;
  assign IRQ_OUT    = ctl_ie & (flg_unplug | flg_plug | flg_irq);

endmodule

// File: tb/tb_prt_dp_pm_hpd_tx.sv
// Directed bench for prt_dp_pm_hpd_tx in simulation mode (plug 5, IRQ min 3, unplug 10 beats).
module tb_prt_dp_pm_hpd_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic beat = 1'b0;
  logic hpd = 1'b0;
  logic irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          low_beats;
    logic [31:0] exp_sta;
    logic [31:0] exp_pw;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[4];

  prt_dp_lb_if lb_if ();

  prt_dp_pm_hpd_tx #(.P_SIM(1)) dut (
    .CLK_IN  (clk),
    .RST_IN  (rst),
    .LB_IF   (lb_if),
    .BEAT_IN (beat),
    .HPD_IN  (hpd),
    .IRQ_OUT (irq)
  );

  always #5 clk = ~clk;

  // Beat: 16-cycle period, changed just after a clock edge.
  initial begin
    forever begin
      repeat (8) @(posedge clk);
      #1 beat = 1'b1;
      repeat (8) @(posedge clk);
      #1 beat = 1'b0;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic lb_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    lb_if.wr  = 1'b1;
    lb_if.adr = a;
    lb_if.din = d;
    @(posedge clk);
    #1;
    lb_if.wr  = 1'b0;
  endtask

  task automatic expect_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    @(posedge clk);
    #1;
    lb_if.rd  = 1'b1;
    lb_if.adr = a;
    @(posedge clk);
    #1;
    d = lb_if.dout;
    check({name, "_vld"}, 32'(lb_if.vld), 32'd1);
    check(name, d, exp);
    lb_if.rd = 1'b0;
  endtask

  // Lands two clocks after the next beat rising edge, once that beat is counted.
  task automatic beat_sync();
    @(posedge beat);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic low_pulse(input int n);
    beat_sync();
    hpd = 1'b0;
    repeat (n) beat_sync();
    hpd = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{low_beats: 5, exp_sta: 32'h9, exp_pw: 32'd5, exp_irq: 1'b1};
    vecs[1] = '{low_beats: 2, exp_sta: 32'h1, exp_pw: 32'd5, exp_irq: 1'b0};
    vecs[2] = '{low_beats: 3, exp_sta: 32'h9, exp_pw: 32'd3, exp_irq: 1'b1};
    vecs[3] = '{low_beats: 9, exp_sta: 32'h9, exp_pw: 32'd9, exp_irq: 1'b1};

    lb_if.adr = '0;
    lb_if.din = '0;
    lb_if.rd  = 1'b0;
    lb_if.wr  = 1'b0;

    // Reset state
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_vld", 32'(lb_if.vld), 32'd0);
    expect_reg("rst_ctl", 2'd0, 32'd0);
    expect_reg("rst_sta", 2'd1, 32'd0);
    expect_reg("rst_pw", 2'd2, 32'd0);
    expect_reg("id", 2'd3, 32'hdeadcafe);

    // Plug debounce: not yet at beat 4, plugged at beat 5
    lb_write(2'd0, 32'h3);
    expect_reg("ctl", 2'd0, 32'h3);
    beat_sync();
    hpd = 1'b1;
    repeat (4) beat_sync();
    expect_reg("plug_early_sta", 2'd1, 32'h0);
    beat_sync();
    expect_reg("plug_sta", 2'd1, 32'h5);
    check("plug_irq", 32'(irq), 32'd1);
    lb_write(2'd1, 32'h4);
    expect_reg("plug_clr_sta", 2'd1, 32'h1);
    check("plug_clr_irq", 32'(irq), 32'd0);

    // Low pulse classification table
    for (int i = 0; i < 4; i++) begin
      lb_write(2'd1, 32'hE);
      low_pulse(vecs[i].low_beats);
      expect_reg($sformatf("pulse%0d_sta", i), 2'd1, vecs[i].exp_sta);
      expect_reg($sformatf("pulse%0d_pw", i), 2'd2, vecs[i].exp_pw);
      check($sformatf("pulse%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
    end

    // W1C on irq flag lands in the same cycle as a new IRQ decision
    beat_sync();
    hpd = 1'b0;
    repeat (5) beat_sync();
    hpd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lb_if.wr  = 1'b1;
    lb_if.adr = 2'd1;
    lb_if.din = 32'h8;
    @(posedge clk);
    #1;
    lb_if.wr = 1'b0;
    repeat (3) @(posedge clk);
    expect_reg("race_sta", 2'd1, 32'h9);
    lb_write(2'd1, 32'h8);
    expect_reg("race_clr_sta", 2'd1, 32'h1);

    // Held low: still plugged at beat 9, unplug at beat 10
    beat_sync();
    hpd = 1'b0;
    repeat (9) beat_sync();
    expect_reg("unplug_early_sta", 2'd1, 32'h1);
    beat_sync();
    expect_reg("unplug_sta", 2'd1, 32'h2);
    expect_reg("unplug_pw", 2'd2, 32'd10);
    check("unplug_irq", 32'(irq), 32'd1);
    lb_write(2'd1, 32'hE);
    beat_sync();
    hpd = 1'b1;
    repeat (3) beat_sync();
    hpd = 1'b0;
    repeat (4) beat_sync();
    expect_reg("short_high_sta", 2'd1, 32'h0);
    check("short_high_irq", 32'(irq), 32'd0);

    // Clearing run mid-pulse drops everything; re-enable replugs cleanly
    beat_sync();
    hpd = 1'b1;
    repeat (6) beat_sync();
    lb_write(2'd1, 32'hE);
    expect_reg("abort_pre_sta", 2'd1, 32'h1);
    beat_sync();
    hpd = 1'b0;
    repeat (2) beat_sync();
    lb_write(2'd0, 32'h0);
    expect_reg("abort_sta", 2'd1, 32'h0);
    expect_reg("abort_pw", 2'd2, 32'h0);
    expect_reg("abort_ctl", 2'd0, 32'h0);
    hpd = 1'b1;
    repeat (2) beat_sync();
    lb_write(2'd0, 32'h3);
    expect_reg("rerun_sta", 2'd1, 32'h0);
    check("rerun_irq", 32'(irq), 32'd0);
    repeat (7) beat_sync();
    expect_reg("rerun_plug_sta", 2'd1, 32'h5);
    expect_reg("rerun_pw", 2'd2, 32'h0);

    // Asynchronous reset in the middle of a low pulse
    beat_sync();
    hpd = 1'b0;
    repeat (2) beat_sync();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst2_irq", 32'(irq), 32'd0);
    expect_reg("rst2_ctl", 2'd0, 32'h0);
    expect_reg("rst2_sta", 2'd1, 32'h0);
    expect_reg("rst2_pw", 2'd2, 32'h0);
    expect_reg("rst2_id", 2'd3, 32'hdeadcafe);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prt_dp_pm_hpd_tx.md
# prt_dp_pm_hpd_tx

Source-side HPD receiver for the DisplayPort policy maker. It samples the HPD pin driven by the sink (the HPD generator on the RX side) and measures its low pulses against the 1 MHz beat. It classifies them into plug, unplug and IRQ events, and exposes sticky status flags, a pulse-width capture register and a level interrupt over the local bus.

## Interface
Parameters:
- P_SIM, 0, simulation mode; shortens all time constants.

Ports:
- CLK_IN  in  1  system clock
- RST_IN  in  1  reset; asynchronous, active-high
- LB_IF  prt_dp_lb_if.lb_in  —  local bus slave; adr 2 bits, din/dout 32 bits, rd, wr, vld
- BEAT_IN  in  1  1 MHz beat; only its rising edge is used
- HPD_IN  in  1  HPD pin from connector; asynchronous to CLK_IN
- IRQ_OUT  out  1  interrupt, level, active-high

## Operation
Constants (in beats, 1 beat = 1 us):
- P_PLUG_VAL: 100, or 5 when P_SIM.
- P_IPW_MIN: 250, or 3 when P_SIM.
- P_HMS_VAL: 2000, or 10 when P_SIM.

Register map (word address):
- 0 CTL, R/W: bit0 run, bit1 ie.
- 1 STA: bit0 level (debounced connected, read-only); bits 1, 2, 3 are the unplug, plug and irq flags (sticky, write-1-to-clear).
- 2 PW, read-only: [15:0] width of the last classified low pulse, in beats.
- 3: reads 0xdeadcafe.

Datapath:
- HPD_IN passes through a 2-FF synchronizer, then an edge detector.
- Counter: 16 bits, increments on each beat rising edge, saturates at 0xFFFF, cleared on every state entry.

State machine (forced to sm_rst while run=0):
- sm_rst: level=0. Next state is sm_unplugged.
- sm_unplugged:
  - Synced HPD high → sm_plug_dbc.
- sm_plug_dbc:
  - HPD low → sm_unplugged, no event.
  - cnt == P_PLUG_VAL → set plug flag, level=1, go to sm_plugged.
- sm_plugged:
  - HPD falling edge → sm_low.
- sm_low:
  - cnt == P_HMS_VAL while low → set unplug flag, level=0, PW=cnt, go to sm_unplugged.
  - HPD rising edge with cnt < P_IPW_MIN → glitch; back to sm_plugged, no event, PW unchanged.
  - HPD rising edge with P_IPW_MIN ≤ cnt < P_HMS_VAL → set irq flag, PW=cnt, go to sm_plugged.

Flags and interrupt:
- IRQ_OUT = ie & (unplug | plug | irq).
- While run=0: flags, level and PW are held at 0.
- A W1C write and a new event on the same flag in the same cycle: the event wins and the flag stays set.
- Writes to CTL take effect the next cycle. Clearing run mid-pulse aborts classification and no event is recorded.

## Timing
- Reset values: IRQ_OUT=0, LB_IF.vld=0, CTL=0, STA=0, PW=0, state sm_rst.
- Local bus inputs are registered once. LB_IF.dout and LB_IF.vld are combinational from the registered rd/adr, so read latency is 1 cycle from LB_IF.rd.
- HPD_IN to the internal synced value: 2 cycles. Edge detect adds 1 more.
- An event flag sets 1 cycle after its decision condition. IRQ_OUT rises in the same cycle as the flag.
- Beat edge detection adds 1 cycle. Pulse widths are exact to ±1 beat.

## Structure
- Shared package prt_dp_pm_hpd_pkg holds:
  - the state enum;
  - register addresses and CTL/STA bit positions;
  - P_PLUG_VAL, P_IPW_MIN and P_HMS_VAL as functions of P_SIM.
- Reuse prt_dp_lib_edge twice: once for BEAT_IN, once for synced HPD.
- No new sub-module.

## Test plan
All lengths below are in beats, with P_SIM=1.
- Write CTL=3, then drive HPD high for 6 beats → plug flag and level=1 at beat 5, IRQ_OUT=1. Write STA=0x4 → IRQ_OUT=0.
- Plugged, then a 5-beat low pulse → irq flag set on the rising edge, PW=5, level stays 1.
- Plugged, then a 2-beat low pulse → no flag, PW unchanged.
- Plugged, then HPD held low → unplug flag at beat 10, PW=10, level=0. A later 3-beat high does not trigger plug.
- W1C write to the irq flag in the same cycle a new IRQ is classified → flag remains 1.
- Clear run during a low pulse, then set run again with HPD high → state restarts at sm_rst, no stale events, plug after 5 beats. Asserting RST_IN mid-pulse → all registers read 0.
